serial_frame_packer: RTL
========================

# serial_frame_packer

Downstream consumer of the serial transmit controller. It samples the serial bit stream while the controller's `outvalid` strobe (`in_valid` here) is high and packs the bits MSB-first into WIDTH-bit words. Completed words, and the zero-padded tail of each frame, go into a small first-word-fall-through FIFO with a valid/ready handshake. Each word is tagged with a last-of-frame flag and a valid-bit count.

## Interface
- `WIDTH`, 8, word width in bits (≥2)
- `DEPTH`, 4, FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `sin`  in  1  serial data bit, sampled when `in_valid`=1
- `in_valid`  in  1  bit strobe from upstream `outvalid`; contiguous high run = one frame
- `out_data`  out  WIDTH  FIFO head word
- `out_count`  out  $clog2(WIDTH+1)  valid bits in `out_data` (1..WIDTH)
- `out_last`  out  1  head word is the final word of its frame
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts head when `out_valid`&&`out_ready`
- `overflow`  out  1  sticky: a word was dropped because the FIFO was full
- `clr_ovf`  in  1  synchronous clear of `overflow`

## Operation
- Internal state: shift register `sr[WIDTH-1:0]`, `bitcnt` (0..WIDTH-1), stage register `stg` with `stg_v`, FSM {IDLE, SHIFT}.
- Reset (async, `rst_n`=0): FSM=IDLE, `sr`=0, `bitcnt`=0, `stg_v`=0, FIFO empty. Outputs: `out_valid`=0, `out_data`=0, `out_count`=0, `out_last`=0, `overflow`=0.
- IDLE:
  - `in_valid`=1: shift `sin` in, `bitcnt`=1, go to SHIFT.
  - `in_valid`=0: stay.
- SHIFT, `in_valid`=1:
  - Shift `sin` in and increment `bitcnt`.
  - If `stg_v`=1, push `stg` with `last`=0 and clear `stg_v`.
  - When the shift fills the word (WIDTH bits), load `stg` with the word (count=WIDTH), set `stg_v`=1, reset `bitcnt`=0.
  - The push and the new stage load may occur in the same cycle.
- SHIFT, `in_valid`=0 (frame end): exactly one push, then go to IDLE.
  - If `stg_v`=1, `bitcnt` is 0: push `stg` with `last`=1.
  - Otherwise: push partial word with `last`=1 and `count`=`bitcnt`. Bits are left-aligned in `[WIDTH-1:WIDTH-bitcnt]`, low bits zero.
  - `stg_v` and `bitcnt`>0 are never both true at frame end.
- Bit order: the first bit of each word lands in the MSB.
- Push when FIFO full and no pop this cycle: the word is dropped and `overflow` is set. Packing continues unaffected.
- Push and pop in the same cycle when full: both are accepted and occupancy is unchanged.
- `clr_ovf` and a new overflow in the same cycle: `overflow` stays 1.
- A 1-cycle `in_valid` gap ends the frame. The next high cycle starts a new frame from IDLE.

## Timing
- A pushed word is visible on `out_*` with `out_valid`=1 on the cycle after the push edge when the FIFO was empty (fall-through from a registered array).
- Frame-end latency: a word is presented one cycle after the first `in_valid`=0 cycle.
- A full word completed mid-frame is held in `stg` until the next bit, or the frame end, decides its `last`. Worst case it is presented 2 cycles after its final bit.
- Pop takes effect at the clock edge where `out_valid`&&`out_ready`. The next entry appears the following cycle.
- At most one push and one pop per cycle.
- Reset asserted mid-frame discards partial bits, the stage and all FIFO contents immediately.

## Configuration
- `SERIAL_FRAME_PACKER_PARITY_EN` defined:
  - Each FIFO entry additionally stores the even parity (XOR) of its `WIDTH` data bits, padding zeros included.
  - Adds output `out_parity` (1 bit, reset 0), aligned with `out_data`.
- Not defined: no parity storage and no `out_parity` port. All other behaviour is identical.

## Test plan
- WIDTH=8, 8-bit frame 1011_0010 → one word 0xB2, `count`=8, `last`=1, `out_valid` one cycle after `in_valid` falls.
- 11-bit frame 1111_0000_101 → words 0xF0 (`count` 8, `last` 0) then 0xA0 (`count` 3, `last` 1).
- Two 4-bit frames 1001, 0110 separated by a 1-cycle gap → 0x90 and 0x60, both `count` 4, `last` 1.
- `out_ready`=0, DEPTH=4, six 8-bit frames → four words held, `overflow`=1, words 5–6 lost; `clr_ovf` → 0.
- FIFO full with `out_ready`=1 on the same cycle a frame ends → the new word is accepted, `overflow` stays 0, order is preserved.
- `rst_n` pulsed low after 5 bits of a frame → `out_valid`=0 immediately; a subsequent 8-bit frame 0x55 is output clean.

Source files
------------

// File: rtl/serial_frame_packer.sv
// serial_frame_packer: packs a framed serial bit stream MSB-first into tagged words behind a FWFT FIFO.
// Optional SERIAL_FRAME_PACKER_PARITY_EN stores per-word even parity and adds out_parity.
module serial_frame_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sin,
    input  logic                         in_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(WIDTH+1)-1:0]   out_count,
    output logic                         out_last,
`ifdef SERIAL_FRAME_PACKER_PARITY_EN
    output logic                         out_parity,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overflow,
    input  logic                         clr_ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  sr, sr_n, stg, stg_n, push_data;
    logic [CW-1:0]     bitcnt, bitcnt_n, push_count;
    logic              stg_v, stg_v_n, push, push_last;
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              full, pop, wr_en, drop;

    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [CW-1:0]     mem_c [DEPTH];
    logic              mem_l [DEPTH];

    // A completed word waits in stg until the next bit or the frame end decides its last flag.
    always_comb begin
        state_n    = state;
        sr_n       = sr;
        bitcnt_n   = bitcnt;
        stg_n      = stg;
        stg_v_n    = stg_v;
        push       = 1'b0;
        push_data  = stg;
        push_count = CW'(WIDTH);
        push_last  = 1'b0;
        if (in_valid) begin
            sr_n     = {sr[WIDTH-2:0], sin};
            state_n  = SHIFT;
            bitcnt_n = bitcnt + 1'b1;
            if (state == SHIFT && stg_v) begin
                push    = 1'b1;
                stg_v_n = 1'b0;
            end
            if (bitcnt == CW'(WIDTH - 1)) begin
                stg_n    = sr_n;
                stg_v_n  = 1'b1;
                bitcnt_n = '0;
            end
        end else if (state == SHIFT) begin
            push      = 1'b1;
            push_last = 1'b1;
            state_n   = IDLE;
            stg_v_n   = 1'b0;
            bitcnt_n  = '0;
            if (!stg_v) begin
                push_data  = sr << (CW'(WIDTH) - bitcnt);
                push_count = bitcnt;
            end
        end
    end

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = wr_ptr != rd_ptr;
    assign pop       = out_valid && out_ready;
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign out_data  = out_valid ? mem_d[rd_ptr[AW-1:0]] : '0;
    assign out_count = out_valid ? mem_c[rd_ptr[AW-1:0]] : '0;
    assign out_last  = out_valid && mem_l[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            bitcnt   <= '0;
            stg      <= '0;
            stg_v    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            bitcnt   <= bitcnt_n;
            stg      <= stg_n;
            stg_v    <= stg_v_n;
            wr_ptr   <= wr_ptr + AW'(wr_en);
            rd_ptr   <= rd_ptr + AW'(pop);
            overflow <= (overflow && !clr_ovf) || drop;
        end
    end

    // Storage needs no reset: outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_d[wr_ptr[AW-1:0]] <= push_data;
            mem_c[wr_ptr[AW-1:0]] <= push_count;
            mem_l[wr_ptr[AW-1:0]] <= push_last;
        end
    end

`ifdef SERIAL_FRAME_PACKER_PARITY_EN
    logic mem_p [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem_p[wr_ptr[AW-1:0]] <= ^push_data;
    end

    assign out_parity = out_valid && mem_p[rd_ptr[AW-1:0]];
`endif
endmodule
